// File: rtl/srm_controller.sv
// srm_controller: instruction register, decoder and control FSM for the
// Simple RISC Machine. Latches a 16-bit instruction word, decodes it and
// drives every datapath control input, one state per cycle, until the
// instruction retires.
//
// Optional feature macro: SRM_ILLEGAL_TRAP_EN
//   defined   - an undefined instruction parks the FSM in HALT and raises
//               the sticky 'illegal' flag; only reset_n leaves HALT.
//   undefined - an undefined instruction behaves as a NOP and 'illegal'
//               is tied low.
//
// All control outputs are registered Moore outputs: they are computed from
// the state being entered and loaded on the same edge as the state register,
// so they are glitch-free and valid one clk->q after each edge.

module srm_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic        illegal,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
`ifdef SRM_ILLEGAL_TRAP_EN
        ,
        S_HALT      = 3'd7
`endif
    } state_t;

    // Instruction register and FSM state
    logic [15:0] r_ir;
    state_t      r_state;

    // Registered control outputs
    logic        r_w;
    logic        r_loada;
    logic        r_loadb;
    logic        r_loadc;
    logic        r_loads;
    logic        r_write;
    logic        r_asel;
    logic [1:0]  r_vsel;
    logic [2:0]  r_num;
    logic [1:0]  r_shift;
    logic [1:0]  r_aluop;

    // Instruction fields
    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;

    // Instruction class decode
    logic        w_isMovImm;
    logic        w_isMovReg;
    logic        w_isAluOp;
    logic        w_isCmp;
    logic        w_isMvn;
    logic        w_needsA;
    logic        w_shiftEn;

    // Next state and the outputs that belong to it
    state_t      w_nextState;
    logic        w_nextW;
    logic        w_nextLoada;
    logic        w_nextLoadb;
    logic        w_nextLoadc;
    logic        w_nextLoads;
    logic        w_nextWrite;
    logic        w_nextAsel;
    logic [1:0]  w_nextVsel;
    logic [2:0]  w_nextNum;
    logic [1:0]  w_nextShift;
    logic [1:0]  w_nextAluop;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_isMovImm = (w_opcode == 3'b110) && (w_op == 2'b10);
    assign w_isMovReg = (w_opcode == 3'b110) && (w_op == 2'b00);
    assign w_isAluOp  = (w_opcode == 3'b101);
    assign w_isCmp    = w_isAluOp && (w_op == 2'b01);
    assign w_isMvn    = w_isAluOp && (w_op == 2'b11);
    // ADD, CMP and AND read Rn into A; MVN and MOV reg only use B
    assign w_needsA   = w_isAluOp && !w_isMvn;
    // Shifter field is meaningful for every ALU instruction and MOV reg
    assign w_shiftEn  = w_isAluOp || w_isMovReg;

    // Immediates follow the IR continuously so the datapath sees them early
    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

    // B input always comes from the register file for this instruction set
    assign bsel = 1'b0;

    // IR captures the instruction word only while the FSM is idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= 16'h0000;
        end else if (load && (r_state == S_WAIT)) begin
            r_ir <= in;
        end
    end

    // Next-state selection; DECODE branches on the instruction class
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_WAIT: begin
                if (s) begin
                    w_nextState = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_isMovImm) begin
                    w_nextState = S_WRITE_IMM;
                end else if (w_needsA) begin
                    w_nextState = S_GET_A;
                end else if (w_isMovReg || w_isMvn) begin
                    w_nextState = S_GET_B;
                end else begin
`ifdef SRM_ILLEGAL_TRAP_EN
                    w_nextState = S_HALT;
`else
                    w_nextState = S_WAIT;
`endif
                end
            end
            S_GET_A:     w_nextState = S_GET_B;
            S_GET_B:     w_nextState = S_ALU;
            S_ALU:       w_nextState = w_isCmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: w_nextState = S_WAIT;
            S_WRITE_REG: w_nextState = S_WAIT;
`ifdef SRM_ILLEGAL_TRAP_EN
            S_HALT:      w_nextState = S_HALT;
`endif
            default:     w_nextState = S_WAIT;
        endcase
    end

    // Moore output values for the state being entered; anything not named is 0
    always_comb begin
        w_nextW     = 1'b0;
        w_nextLoada = 1'b0;
        w_nextLoadb = 1'b0;
        w_nextLoadc = 1'b0;
        w_nextLoads = 1'b0;
        w_nextWrite = 1'b0;
        w_nextAsel  = 1'b0;
        w_nextVsel  = 2'b00;
        w_nextNum   = 3'b000;
        w_nextShift = 2'b00;
        w_nextAluop = 2'b00;
        case (w_nextState)
            S_WAIT: begin
                w_nextW = 1'b1;
            end
            S_WRITE_IMM: begin
                w_nextWrite = 1'b1;
                w_nextVsel  = 2'b01;
                w_nextNum   = w_rn;
            end
            S_GET_A: begin
                w_nextLoada = 1'b1;
                w_nextNum   = w_rn;
            end
            S_GET_B: begin
                w_nextLoadb = 1'b1;
                w_nextNum   = w_rm;
                w_nextShift = w_shiftEn ? w_sh : 2'b00;
            end
            S_ALU: begin
                w_nextLoadc = !w_isCmp;
                w_nextLoads = w_isCmp;
                w_nextAsel  = w_isMovReg;
                w_nextAluop = w_isMovReg ? 2'b00 : w_op;
                w_nextShift = w_shiftEn ? w_sh : 2'b00;
            end
            S_WRITE_REG: begin
                w_nextWrite = 1'b1;
                w_nextVsel  = 2'b00;
                w_nextNum   = w_rd;
            end
            default: begin
                w_nextW = 1'b0;
            end
        endcase
    end

    // Control FSM: state and all control outputs advance together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
            r_w     <= 1'b1;
            r_loada <= 1'b0;
            r_loadb <= 1'b0;
            r_loadc <= 1'b0;
            r_loads <= 1'b0;
            r_write <= 1'b0;
            r_asel  <= 1'b0;
            r_vsel  <= 2'b00;
            r_num   <= 3'b000;
            r_shift <= 2'b00;
            r_aluop <= 2'b00;
        end else begin
            r_state <= w_nextState;
            r_w     <= w_nextW;
            r_loada <= w_nextLoada;
            r_loadb <= w_nextLoadb;
            r_loadc <= w_nextLoadc;
            r_loads <= w_nextLoads;
            r_write <= w_nextWrite;
            r_asel  <= w_nextAsel;
            r_vsel  <= w_nextVsel;
            r_num   <= w_nextNum;
            r_shift <= w_nextShift;
            r_aluop <= w_nextAluop;
        end
    end

`ifdef SRM_ILLEGAL_TRAP_EN
    logic r_illegal;

    // Sticky trap flag, raised on entry to HALT and cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else if (w_nextState == S_HALT) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign w        = r_w;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign write    = r_write;
    assign asel     = r_asel;
    assign vsel     = r_vsel;
    assign readnum  = r_num;
    assign writenum = r_num;
    assign shift    = r_shift;
    assign ALUop    = r_aluop;

endmodule

// File: tb/tb_srm_controller.sv
// tb_srm_controller: table-driven bench for srm_controller. Each table row
// is one clock cycle: inputs driven at the falling edge, outputs compared
// one time unit after the following rising edge. Hand-written sequences
// cover reset in the middle of an instruction and undefined instructions.

module tb_srm_controller;

    logic        clk;
    logic        resetN;
    logic        sIn;
    logic        loadIn;
    logic [15:0] irIn;
    logic        w;
    logic        illegal;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  aluOp;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    int applied;
    int miscompares;

    // Control-bit groups, ordered {loada, loadb, loadc, loads, write, asel, bsel}
    localparam logic [6:0] CN  = 7'b0000000;
    localparam logic [6:0] CA  = 7'b1000000;
    localparam logic [6:0] CB  = 7'b0100000;
    localparam logic [6:0] CC  = 7'b0010000;
    localparam logic [6:0] CS  = 7'b0001000;
    localparam logic [6:0] CW  = 7'b0000100;
    localparam logic [6:0] CAS = 7'b0000010;

    typedef struct {
        logic        rstN;
        logic        sVal;
        logic        loadVal;
        logic [15:0] irWord;
        logic [52:0] expOut;
    } vec_t;

    vec_t vecs[$];

    srm_controller dut (
        .clk      (clk),
        .reset_n  (resetN),
        .s        (sIn),
        .load     (loadIn),
        .in       (irIn),
        .w        (w),
        .illegal  (illegal),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .write    (write),
        .asel     (asel),
        .bsel     (bsel),
        .vsel     (vsel),
        .readnum  (readnum),
        .writenum (writenum),
        .shift    (shift),
        .ALUop    (aluOp),
        .sximm8   (sximm8),
        .sximm5   (sximm5)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [52:0] packExp(
        input logic ew, input logic eIll, input logic [6:0] ctl,
        input logic [1:0] vs, input logic [2:0] num, input logic [1:0] sh,
        input logic [1:0] op, input logic [15:0] x8, input logic [15:0] x5);
        return {ew, eIll, ctl, vs, num, num, sh, op, x8, x5};
    endfunction

    function automatic vec_t mk(
        input logic r, input logic sv, input logic ld, input logic [15:0] ir,
        input logic ew, input logic eIll, input logic [6:0] ctl,
        input logic [1:0] vs, input logic [2:0] num, input logic [1:0] sh,
        input logic [1:0] op, input logic [15:0] x8, input logic [15:0] x5);
        vec_t v;
        v.rstN    = r;
        v.sVal    = sv;
        v.loadVal = ld;
        v.irWord  = ir;
        v.expOut  = packExp(ew, eIll, ctl, vs, num, sh, op, x8, x5);
        return v;
    endfunction

    function automatic logic [52:0] actualOut();
        return {w, illegal, loada, loadb, loadc, loads, write, asel, bsel,
                vsel, readnum, writenum, shift, aluOp, sximm8, sximm5};
    endfunction

    task automatic applyStimulus(input logic r, input logic sv, input logic ld,
                                 input logic [15:0] ir);
        @(negedge clk);
        resetN = r;
        sIn    = sv;
        loadIn = ld;
        irIn   = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [52:0] expected);
        logic [52:0] act;
        act = actualOut();
        applied++;
        if (act !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expected);
        end
    endtask

    initial begin
        logic [52:0] idle;
        logic [52:0] decode0;
        applied     = 0;
        miscompares = 0;
        resetN      = 1'b0;
        sIn         = 1'b1;
        loadIn      = 1'b0;
        irIn        = 16'h0000;

        // Reset held two cycles with s asserted
        vecs.push_back(mk(0,1,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000));
        vecs.push_back(mk(0,1,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000));
        // MOV R0,#-1: load alone, then start
        vecs.push_back(mk(1,0,1,16'hD0FF, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
        vecs.push_back(mk(1,1,0,16'h0000, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b01,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
        // ADD R2,R0,R1,LSL#1 with simultaneous load and s
        vecs.push_back(mk(1,1,1,16'hA049, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0049,16'h0009));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CA, 2'b00,3'd0,2'b00,2'b00, 16'h0049,16'h0009));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CB, 2'b00,3'd1,2'b01,2'b00, 16'h0049,16'h0009));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CC, 2'b00,3'd0,2'b01,2'b00, 16'h0049,16'h0009));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b00,3'd2,2'b00,2'b00, 16'h0049,16'h0009));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0049,16'h0009));
        // CMP R0,R1: status load, no write cycle
        vecs.push_back(mk(1,1,1,16'hA801, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0001,16'h0001));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CA, 2'b00,3'd0,2'b00,2'b00, 16'h0001,16'h0001));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CB, 2'b00,3'd1,2'b00,2'b00, 16'h0001,16'h0001));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CS, 2'b00,3'd0,2'b00,2'b01, 16'h0001,16'h0001));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0001,16'h0001));
        // MOV R4,R1,LSR
        vecs.push_back(mk(1,1,1,16'hC091, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFF91,16'hFFF1));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CB, 2'b00,3'd1,2'b10,2'b00, 16'hFF91,16'hFFF1));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CC|CAS, 2'b00,3'd0,2'b10,2'b00, 16'hFF91,16'hFFF1));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b00,3'd4,2'b00,2'b00, 16'hFF91,16'hFFF1));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFF91,16'hFFF1));
        // MVN R5,R2
        vecs.push_back(mk(1,1,1,16'hB8A2, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFA2,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CB, 2'b00,3'd2,2'b00,2'b00, 16'hFFA2,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CC, 2'b00,3'd0,2'b00,2'b11, 16'hFFA2,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b00,3'd5,2'b00,2'b00, 16'hFFA2,16'h0002));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFA2,16'h0002));
        // MOV R5,#127
        vecs.push_back(mk(1,1,1,16'hD57F, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h007F,16'hFFFF));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b01,3'd5,2'b00,2'b00, 16'h007F,16'hFFFF));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h007F,16'hFFFF));
        // AND R7,R3,R2,ASR with a stray load of 0xB860 while in GET_B
        vecs.push_back(mk(1,1,1,16'hB3FA, 0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFA,16'hFFFA));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CA, 2'b00,3'd3,2'b00,2'b00, 16'hFFFA,16'hFFFA));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CB, 2'b00,3'd2,2'b11,2'b00, 16'hFFFA,16'hFFFA));
        vecs.push_back(mk(1,0,1,16'hB860, 0,0,CC, 2'b00,3'd0,2'b11,2'b10, 16'hFFFA,16'hFFFA));
        vecs.push_back(mk(1,0,0,16'h0000, 0,0,CW, 2'b00,3'd7,2'b00,2'b00, 16'hFFFA,16'hFFFA));
        vecs.push_back(mk(1,0,0,16'h0000, 1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFA,16'hFFFA));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].sVal, vecs[i].loadVal, vecs[i].irWord);
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
        end

        // Reset asserted mid-instruction (ADD in its ALU cycle)
        idle = packExp(1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000);
        applyStimulus(1, 1, 1, 16'hA049);
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("rstmid_alu", packExp(0,0,CC, 2'b00,3'd0,2'b01,2'b00, 16'h0049,16'h0009));
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkOutput("rstmid_async", idle);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("rstmid_hold", idle);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 16'h0000);
            checkOutput($sformatf("rstmid_after%0d", k), idle);
        end

        // Undefined instruction 0x0000
        decode0 = packExp(0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000);
        applyStimulus(1, 1, 1, 16'h0000);
        checkOutput("undef_decode", decode0);
        applyStimulus(1, 0, 0, 16'h0000);
`ifdef SRM_ILLEGAL_TRAP_EN
        checkOutput("undef_halt", packExp(0,1,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 1, 16'hD0FF);
            checkOutput($sformatf("undef_stay%0d", k),
                        packExp(0,1,CN, 2'b00,3'd0,2'b00,2'b00, 16'h0000,16'h0000));
        end
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("undef_reset", idle);
`else
        checkOutput("undef_nop", idle);
        // 110/01 is also undefined and must retire in two edges
        applyStimulus(1, 1, 1, 16'hC8FF);
        checkOutput("undef2_decode", packExp(0,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("undef2_nop", packExp(1,0,CN, 2'b00,3'd0,2'b00,2'b00, 16'hFFFF,16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
